// File: rtl/alarm_setter.sv
// ---------------------------------------------------------------------------
// alarm_setter
//   Writer side of the alarm-compare interface. Holds the alarm minute, hour
//   and day-code registers plus the alarm enable, and lets the user edit them
//   with debounced buttons. The comparator reads amin/ahrs/adays and is gated
//   by armed; sel tells the display which field to blink.
//
//   Optional feature macro: AUTO_REPEAT_EN
//     defined   : holding adv_btn in a SET state auto-repeats the increment
//                 every REPEAT_CYCLES clocks after the initial edge.
//     undefined : exactly one increment per adv_btn rising edge.
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  synchronous, active-high reset
//   mode_btn   in   1  one-cycle pulse: advance edit mode
//   adv_btn    in   1  level: increment selected field on rising edge
//   en_toggle  in   1  one-cycle pulse: toggle alarm enable
//   amin       out  7  alarm minute, 0..MIN_MAX
//   ahrs       out  7  alarm hour, 0..HR_MAX
//   adays      out  7  alarm day code, 0..DAY_MAX
//   alarm_en   out  1  stored alarm enable
//   armed      out  1  alarm_en while in RUN
//   setting    out  1  1 when not in RUN
//   sel        out  2  field under edit: 0 none, 1 min, 2 hr, 3 day
// ---------------------------------------------------------------------------
module alarm_setter #(
   parameter int unsigned MIN_MAX       = 59,
   parameter int unsigned HR_MAX        = 23,
   parameter int unsigned DAY_MAX       = 7,
   parameter int unsigned DAY_RST       = 7,
   parameter int unsigned REPEAT_CYCLES = 50
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       adv_btn,
   input  logic       en_toggle,
   output logic [6:0] amin,
   output logic [6:0] ahrs,
   output logic [6:0] adays,
   output logic       alarm_en,
   output logic       armed,
   output logic       setting,
   output logic [1:0] sel
);

   // Encodings double as the sel value, so sel is a direct decode.
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      SET_MIN = 2'd1,
      SET_HR  = 2'd2,
      SET_DAY = 2'd3
   } state_e;

   state_e     state_q, state_d;
   logic [6:0] amin_q, amin_d;
   logic [6:0] ahrs_q, ahrs_d;
   logic [6:0] adays_q, adays_d;
   logic       en_q, en_d;
   logic       adv_q;

   logic       in_set;
   logic       adv_edge;
   logic       inc_req;
   logic       do_inc;

   // Increment with wrap at the field's last legal value; no carry out.
   function automatic logic [6:0] inc_wrap(input logic [6:0] v, input logic [6:0] max);
      inc_wrap = (v >= max) ? 7'd0 : v + 7'd1;
   endfunction

   assign in_set   = (state_q != RUN);
   assign adv_edge = adv_btn & ~adv_q;

`ifdef AUTO_REPEAT_EN
   // rep_cnt_q counts held cycles since the qualifying edge; 0 means no
   // edge has been seen in this state, so a state change while adv_btn is
   // still held does not start repeating until a fresh edge arrives.
   localparam int CW = $clog2(REPEAT_CYCLES + 1);

   logic [CW-1:0] rep_cnt_q, rep_cnt_d;
   logic          rep_fire;

   assign rep_fire = in_set & adv_btn & adv_q & (rep_cnt_q == CW'(REPEAT_CYCLES));

   always_comb begin
      rep_cnt_d = '0;
      if (in_set && adv_btn && !mode_btn) begin
         if (adv_edge)
            rep_cnt_d = CW'(1);
         else if (rep_cnt_q != '0)
            rep_cnt_d = rep_fire ? CW'(1) : rep_cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) rep_cnt_q <= '0;
      else       rep_cnt_q <= rep_cnt_d;
   end

   assign inc_req = adv_edge | rep_fire;
`else
   logic unused_repeat;
   assign unused_repeat = (REPEAT_CYCLES != 0);
   assign inc_req       = adv_edge;
`endif

   // A mode press in the same cycle as an increment request wins.
   assign do_inc = inc_req & in_set & ~mode_btn;

   always_comb begin
      state_d = state_q;
      amin_d  = amin_q;
      ahrs_d  = ahrs_q;
      adays_d = adays_q;
      en_d    = en_q ^ en_toggle;

      if (mode_btn) begin
         unique case (state_q)
            RUN:     state_d = SET_MIN;
            SET_MIN: state_d = SET_HR;
            SET_HR:  state_d = SET_DAY;
            SET_DAY: state_d = RUN;
            default: state_d = RUN;
         endcase
      end

      if (do_inc) begin
         unique case (state_q)
            SET_MIN: amin_d  = inc_wrap(amin_q,  7'(MIN_MAX));
            SET_HR:  ahrs_d  = inc_wrap(ahrs_q,  7'(HR_MAX));
            SET_DAY: adays_d = inc_wrap(adays_q, 7'(DAY_MAX));
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         amin_q  <= 7'd0;
         ahrs_q  <= 7'd0;
         adays_q <= 7'(DAY_RST);
         en_q    <= 1'b0;
         adv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         amin_q  <= amin_d;
         ahrs_q  <= ahrs_d;
         adays_q <= adays_d;
         en_q    <= en_d;
         adv_q   <= adv_btn;
      end
   end

   assign amin     = amin_q;
   assign ahrs     = ahrs_q;
   assign adays    = adays_q;
   assign alarm_en = en_q;
   assign setting  = in_set;
   assign sel      = state_q;
   // Comparator is held off while any field is mid-edit.
   assign armed    = en_q & ~in_set;

endmodule

// File: tb/tb_alarm_setter.sv
module tb_alarm_setter;

   logic       clk = 1'b0;
   logic       reset, mode_btn, adv_btn, en_toggle;
   logic [6:0] amin, ahrs, adays;
   logic       alarm_en, armed, setting;
   logic [1:0] sel;

   always #5 clk = ~clk;

   alarm_setter #(
      .MIN_MAX(59), .HR_MAX(23), .DAY_MAX(7), .DAY_RST(7), .REPEAT_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .mode_btn(mode_btn), .adv_btn(adv_btn),
      .en_toggle(en_toggle), .amin(amin), .ahrs(ahrs), .adays(adays),
      .alarm_en(alarm_en), .armed(armed), .setting(setting), .sel(sel)
   );

   typedef struct {
      string      name;
      logic [6:0] amin, ahrs, adays;
      logic       en, armed, setting;
      logic [1:0] sel;
   } exp_t;

   exp_t q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Monitor: compares every queued expectation at the falling edge.
   always @(negedge clk) begin
      while (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         vectors++;
         if (amin !== e.amin || ahrs !== e.ahrs || adays !== e.adays ||
             alarm_en !== e.en || armed !== e.armed || setting !== e.setting || sel !== e.sel) begin
            miscompares++;
            $display("FAIL %s: got min=%0d hr=%0d day=%0d en=%b armed=%b set=%b sel=%0d, want min=%0d hr=%0d day=%0d en=%b armed=%b set=%b sel=%0d",
                     e.name, amin, ahrs, adays, alarm_en, armed, setting, sel,
                     e.amin, e.ahrs, e.adays, e.en, e.armed, e.setting, e.sel);
         end
      end
   end

   task automatic step(input logic r, input logic m, input logic a, input logic t);
      reset = r; mode_btn = m; adv_btn = a; en_toggle = t;
      @(posedge clk); #1;
   endtask

   task automatic expect_out(input string n, input int mi, input int hr, input int dy,
                             input logic en, input logic arm, input logic set, input int s);
      exp_t e;
      e.name = n; e.amin = 7'(mi); e.ahrs = 7'(hr); e.adays = 7'(dy);
      e.en = en; e.armed = arm; e.setting = set; e.sel = 2'(s);
      q.push_back(e);
   endtask

   task automatic adv_pulses(input int n);
      for (int i = 0; i < n; i++) begin
         step(0, 0, 1, 0);
         step(0, 0, 0, 0);
      end
   endtask

   initial begin
      int rep_exp;
      reset = 1'b1; mode_btn = 1'b0; adv_btn = 1'b0; en_toggle = 1'b0;

      // 1: reset
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      expect_out("reset", 0, 0, 7, 0, 0, 0, 0);

      // 2: minute and hour edit with wrap
      step(0, 1, 0, 0);
      expect_out("enter_set_min", 0, 0, 7, 0, 0, 1, 1);
      adv_pulses(7);
      expect_out("amin_7", 7, 0, 7, 0, 0, 1, 1);
      step(0, 1, 0, 0);
      expect_out("enter_set_hr", 7, 0, 7, 0, 0, 1, 2);
      adv_pulses(23);
      expect_out("ahrs_max", 7, 23, 7, 0, 0, 1, 2);
      adv_pulses(1);
      expect_out("ahrs_wrap", 7, 0, 7, 0, 0, 1, 2);
      adv_pulses(1);
      expect_out("ahrs_1", 7, 1, 7, 0, 0, 1, 2);

      // 3: day wrap, back to RUN, adv ignored in RUN
      step(0, 1, 0, 0);
      expect_out("enter_set_day", 7, 1, 7, 0, 0, 1, 3);
      adv_pulses(1);
      expect_out("adays_wrap", 7, 1, 0, 0, 0, 1, 3);
      step(0, 1, 0, 0);
      expect_out("back_to_run", 7, 1, 0, 0, 0, 0, 0);
      adv_pulses(2);
      expect_out("adv_in_run", 7, 1, 0, 0, 0, 0, 0);

      // 4: enable / armed gating
      step(0, 0, 0, 1);
      expect_out("en_run", 7, 1, 0, 1, 1, 0, 0);
      step(0, 1, 0, 0);
      expect_out("armed_off_set", 7, 1, 0, 1, 0, 1, 1);
      step(0, 0, 0, 1);
      expect_out("en_toggle_set", 7, 1, 0, 0, 0, 1, 1);
      step(0, 0, 0, 1);
      expect_out("en_toggle_set2", 7, 1, 0, 1, 0, 1, 1);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      expect_out("rearmed_run", 7, 1, 0, 1, 1, 0, 0);

      // 5: mode wins over adv edge; reset mid-edit
      step(1, 0, 0, 0);
      expect_out("reset2", 0, 0, 7, 0, 0, 0, 0);
      step(0, 1, 0, 0);
      adv_pulses(5);
      expect_out("amin_5", 5, 0, 7, 0, 0, 1, 1);
      step(0, 1, 1, 0);
      expect_out("mode_wins", 5, 0, 7, 0, 0, 1, 2);
      step(0, 0, 0, 0);
      adv_pulses(9);
      expect_out("ahrs_9", 5, 9, 7, 0, 0, 1, 2);
      step(1, 0, 0, 0);
      expect_out("reset_mid_edit", 0, 0, 7, 0, 0, 0, 0);

      // 6: held adv for 13 cycles
      step(0, 1, 0, 0);
      for (int i = 0; i < 13; i++) step(0, 0, 1, 0);
`ifdef AUTO_REPEAT_EN
      rep_exp = 4;
`else
      rep_exp = 1;
`endif
      expect_out("adv_held", rep_exp, 0, 7, 0, 0, 1, 1);
      step(0, 0, 0, 0);
      expect_out("adv_release", rep_exp, 0, 7, 0, 0, 1, 1);

      // Drain with a bounded wait.
      for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         miscompares++;
         $display("FAIL drain: got %0d pending, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
